// File: rtl/packet_rx_parser.sv
// Sink of the 64-bit valid/data/byte_enable/sop/eop packet stream: checks framing
// and byte enables, counts packet length, captures a header vector and keeps
// saturating per-packet statistics.
module packet_rx_parser #(
    parameter int unsigned HDR_BYTES = 14,
    parameter int unsigned MAX_LEN   = 1518,
    parameter int unsigned LEN_W     = 16,
    parameter int unsigned CNT_W     = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   valid,
    input  logic [63:0]            data,
    input  logic [7:0]             byte_enable,
    input  logic                   sop,
    input  logic                   eop,
    output logic                   hdr_valid,
    output logic [HDR_BYTES*8-1:0] hdr_data,
    output logic                   pkt_done,
    output logic [LEN_W-1:0]       pkt_len,
    output logic [4:0]             pkt_err_flags,
    output logic [CNT_W-1:0]       pkt_cnt,
    output logic [CNT_W-1:0]       err_cnt,
    output logic [CNT_W-1:0]       drop_cnt
);
    localparam int unsigned        HDR_W     = HDR_BYTES * 8;
    localparam int unsigned        SUM_W     = LEN_W + 1;
    localparam logic [LEN_W-1:0]   LEN_SAT   = '1;
    localparam logic [CNT_W-1:0]   CNT_SAT   = '1;
    localparam logic [LEN_W-1:0]   HDR_LEN   = LEN_W'(HDR_BYTES);
    localparam logic [LEN_W-1:0]   MAX_LEN_L = LEN_W'(MAX_LEN);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             bad_q, bad_d;
    logic             over_q, over_d;
    logic             seen_q, seen_d;
    logic [HDR_W-1:0] hdr_q, hdr_d;
    logic             hdr_valid_q, hdr_valid_d;
    logic             done_q, done_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [4:0]       flags_q, flags_d;
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic [3:0]       beat_bytes_c;
    logic             beat_bad_c;
    logic [LEN_W-1:0] acc_base_c;
    logic [SUM_W-1:0] acc_sum_c;
    logic [LEN_W-1:0] acc_cnt_c;
    logic             acc_bad_c;
    logic             acc_over_c;
    logic             acc_seen_c;
    logic             acc_hit_c;
    logic [HDR_W-1:0] acc_hdr_c;
    logic             take_c;
    logic             close_c;
    logic             drop_c;
    logic [LEN_W-1:0] close_len_c;
    logic [4:0]       close_flags_c;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_SAT) ? v : v + CNT_W'(1);
    endfunction

    // Packet state after this beat is folded in; a sop beat starts from an empty packet
    always_comb begin
        beat_bytes_c = '0;
        for (int i = 0; i < 8; i++) begin
            beat_bytes_c = beat_bytes_c + 4'(byte_enable[i]);
        end
        beat_bad_c = 1'b0;
        if (eop) begin
            beat_bad_c = !(byte_enable inside {8'hFF, 8'hFE, 8'hFC, 8'hF8,
                                               8'hF0, 8'hE0, 8'hC0, 8'h80});
        end else begin
            beat_bad_c = (byte_enable != 8'hFF);
        end
        acc_base_c = sop ? '0 : cnt_q;
        acc_sum_c  = {1'b0, acc_base_c} + SUM_W'(beat_bytes_c);
        acc_cnt_c  = acc_sum_c[LEN_W] ? LEN_SAT : acc_sum_c[LEN_W-1:0];
        acc_bad_c  = (!sop && bad_q) || beat_bad_c;
        acc_over_c = (!sop && over_q) || (acc_cnt_c > MAX_LEN_L);
        acc_hit_c  = !(!sop && seen_q) && (acc_cnt_c >= HDR_LEN);
        acc_seen_c = (!sop && seen_q) || acc_hit_c;
        acc_hdr_c  = sop ? '0 : hdr_q;
        // lane j of the beat lands at packet offset base+j when that is inside the header
        for (int k = 0; k < int'(HDR_BYTES); k++) begin
            for (int j = 0; j < 8; j++) begin
                if (k >= j && byte_enable[7-j] && acc_base_c == LEN_W'(k - j)) begin
                    acc_hdr_c[(HDR_W - 8) - 8*k +: 8] = data[8*(7-j) +: 8];
                end
            end
        end
    end

    // Framing FSM: decides accept / close / drop for each valid beat
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bad_d         = bad_q;
        over_d        = over_q;
        seen_d        = seen_q;
        hdr_d         = hdr_q;
        hdr_valid_d   = 1'b0;
        done_d        = 1'b0;
        len_d         = len_q;
        flags_d       = flags_q;
        pkt_cnt_d     = pkt_cnt_q;
        err_cnt_d     = err_cnt_q;
        drop_cnt_d    = drop_cnt_q;
        take_c        = 1'b0;
        close_c       = 1'b0;
        drop_c        = 1'b0;
        close_len_c   = cnt_q;
        close_flags_c = '0;

        if (valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (sop) begin
                        take_c  = 1'b1;
                        state_d = eop ? ST_IDLE : ST_IN_PKT;
                    end else begin
                        drop_c = 1'b1;
                    end
                end
                ST_IN_PKT: begin
                    if (sop) begin
                        // previous packet never saw eop; it closes with what it had
                        close_c       = 1'b1;
                        close_len_c   = cnt_q;
                        close_flags_c = {1'b0, 1'b1, bad_q, over_q, cnt_q < HDR_LEN};
                        if (eop) begin
                            drop_c  = 1'b1;
                            hdr_d   = '0;
                            state_d = ST_IDLE;
                        end else begin
                            take_c = 1'b1;
                        end
                    end else begin
                        take_c = 1'b1;
                        if (eop) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (take_c) begin
            cnt_d       = acc_cnt_c;
            bad_d       = acc_bad_c;
            over_d      = acc_over_c;
            seen_d      = acc_seen_c;
            hdr_d       = acc_hdr_c;
            hdr_valid_d = acc_hit_c;
            if (eop) begin
                close_c       = 1'b1;
                close_len_c   = acc_cnt_c;
                close_flags_c = {1'b0, 1'b0, acc_bad_c, acc_over_c, acc_cnt_c < HDR_LEN};
            end
        end

        if (close_c) begin
            done_d  = 1'b1;
            len_d   = close_len_c;
            flags_d = close_flags_c;
            if (close_flags_c == '0) begin
                pkt_cnt_d = sat_inc(pkt_cnt_q);
            end else begin
                err_cnt_d = sat_inc(err_cnt_q);
            end
        end

        if (drop_c) begin
            drop_cnt_d = sat_inc(drop_cnt_q);
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Packet tracking, header and result/statistics registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            bad_q       <= 1'b0;
            over_q      <= 1'b0;
            seen_q      <= 1'b0;
            hdr_q       <= '0;
            hdr_valid_q <= 1'b0;
            done_q      <= 1'b0;
            len_q       <= '0;
            flags_q     <= '0;
            pkt_cnt_q   <= '0;
            err_cnt_q   <= '0;
            drop_cnt_q  <= '0;
        end else begin
            cnt_q       <= cnt_d;
            bad_q       <= bad_d;
            over_q      <= over_d;
            seen_q      <= seen_d;
            hdr_q       <= hdr_d;
            hdr_valid_q <= hdr_valid_d;
            done_q      <= done_d;
            len_q       <= len_d;
            flags_q     <= flags_d;
            pkt_cnt_q   <= pkt_cnt_d;
            err_cnt_q   <= err_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign hdr_valid     = hdr_valid_q;
    assign hdr_data      = hdr_q;
    assign pkt_done      = done_q;
    assign pkt_len       = len_q;
    assign pkt_err_flags = flags_q;
    assign pkt_cnt       = pkt_cnt_q;
    assign err_cnt       = err_cnt_q;
    assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_packet_rx_parser.sv
// Bench for packet_rx_parser: directed vector table, hand sequences for oversize
// and mid-packet reset, then random traffic against a packet-level reference model.
module tb_packet_rx_parser;
    localparam int HDR  = 14;
    localparam int MAXL = 1518;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              valid;
    logic [63:0]       data;
    logic [7:0]        be;
    logic              sop;
    logic              eop;
    logic              hdr_valid;
    logic [HDR*8-1:0]  hdr_data;
    logic              pkt_done;
    logic [15:0]       pkt_len;
    logic [4:0]        pkt_err_flags;
    logic [31:0]       pkt_cnt;
    logic [31:0]       err_cnt;
    logic [31:0]       drop_cnt;

    always #5 clk = ~clk;

    packet_rx_parser dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .valid         (valid),
        .data          (data),
        .byte_enable   (be),
        .sop           (sop),
        .eop           (eop),
        .hdr_valid     (hdr_valid),
        .hdr_data      (hdr_data),
        .pkt_done      (pkt_done),
        .pkt_len       (pkt_len),
        .pkt_err_flags (pkt_err_flags),
        .pkt_cnt       (pkt_cnt),
        .err_cnt       (err_cnt),
        .drop_cnt      (drop_cnt)
    );

    int checks = 0;
    int errors = 0;

    // reference model: one open packet described by its byte total and header bytes
    bit         m_open;
    int         m_len;
    bit         m_bad;
    bit         m_fired;
    logic [7:0] m_hb [HDR];
    bit         e_hv;
    bit         e_done;
    int         e_len;
    logic [4:0] e_fl;
    int         e_pkt;
    int         e_err;
    int         e_drop;

    logic [7:0] legal_eop [8] = '{8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};

    typedef struct {
        bit         v;
        bit         s;
        bit         e;
        logic [7:0] b;
        int         base;
        bit         hv;
        bit         done;
        int         len;
        logic [4:0] fl;
        int         pkt;
        int         err;
        int         drop;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] mk(input int b);
        logic [63:0] r;
        for (int j = 0; j < 8; j++) r[63-8*j -: 8] = 8'(b + j);
        return r;
    endfunction

    function automatic logic [HDR*8-1:0] m_hdr_vec();
        logic [HDR*8-1:0] r;
        for (int i = 0; i < HDR; i++) r[HDR*8-1-8*i -: 8] = m_hb[i];
        return r;
    endfunction

    task automatic m_reset();
        m_open = 0; m_len = 0; m_bad = 0; m_fired = 0;
        foreach (m_hb[i]) m_hb[i] = 8'h00;
        e_hv = 0; e_done = 0; e_len = 0; e_fl = '0;
        e_pkt = 0; e_err = 0; e_drop = 0;
    endtask

    task automatic m_close(input bit missing);
        logic [4:0] fl;
        fl = {1'b0, missing, m_bad, m_len > MAXL, m_len < HDR};
        e_done = 1;
        e_fl   = fl;
        e_len  = (m_len > 65535) ? 65535 : m_len;
        if (fl == 5'd0) e_pkt++;
        else e_err++;
        m_open = 0;
    endtask

    task automatic m_beat(input bit v, input bit s, input bit e,
                          input logic [7:0] b, input logic [63:0] d);
        bit legal;
        e_hv   = 0;
        e_done = 0;
        if (!v) return;
        if (!m_open && !s) begin
            e_drop++;
            return;
        end
        if (m_open && s) begin
            m_close(1'b1);
            if (e) begin
                e_drop++;
                foreach (m_hb[i]) m_hb[i] = 8'h00;
                return;
            end
        end
        if (s) begin
            m_open = 1; m_len = 0; m_bad = 0; m_fired = 0;
            foreach (m_hb[i]) m_hb[i] = 8'h00;
        end
        legal = e ? (b inside {8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80})
                  : (b == 8'hFF);
        for (int j = 0; j < 8; j++) begin
            if (b[7-j] && (m_len + j) < HDR) m_hb[m_len + j] = d[63-8*j -: 8];
        end
        m_len += $countones(b);
        if (!legal) m_bad = 1;
        if (!m_fired && m_len >= HDR) begin
            m_fired = 1;
            e_hv    = 1;
        end
        if (e) m_close(1'b0);
    endtask

    task automatic compare_all(input string tag);
        chk({tag, "_hdr_valid"}, hdr_valid, e_hv);
        chk({tag, "_pkt_done"}, pkt_done, e_done);
        chk({tag, "_pkt_len"}, pkt_len, 128'(e_len));
        chk({tag, "_flags"}, pkt_err_flags, e_fl);
        chk({tag, "_pkt_cnt"}, pkt_cnt, 128'(e_pkt));
        chk({tag, "_err_cnt"}, err_cnt, 128'(e_err));
        chk({tag, "_drop_cnt"}, drop_cnt, 128'(e_drop));
        chk({tag, "_hdr_data"}, hdr_data, m_hdr_vec());
    endtask

    task automatic beat(input string tag, input bit v, input bit s, input bit e,
                        input logic [7:0] b, input logic [63:0] d);
        valid = v; sop = s; eop = e; be = b; data = d;
        @(posedge clk);
        #1;
        m_beat(v, s, e, b, d);
        compare_all(tag);
    endtask

    task automatic add_vec(input bit v, input bit s, input bit e, input logic [7:0] b,
                           input int base, input bit hv, input bit done, input int len,
                           input logic [4:0] fl, input int pkt, input int err, input int drop);
        vec_t t;
        t = '{v, s, e, b, base, hv, done, len, fl, pkt, err, drop};
        tbl.push_back(t);
    endtask

    initial begin
        //       v  s  e  be     base  hv done len fl     pkt err drop
        add_vec(1, 1, 0, 8'hFF, 0,    0, 0,   0,  5'h00, 0, 0, 0);  // 20B packet
        add_vec(1, 0, 0, 8'hFF, 8,    1, 0,   0,  5'h00, 0, 0, 0);
        add_vec(1, 0, 1, 8'hF0, 16,   0, 1,   20, 5'h00, 1, 0, 0);
        add_vec(1, 1, 1, 8'hFF, 0,    0, 1,   8,  5'h01, 1, 1, 0);  // single-beat runt
        add_vec(1, 1, 0, 8'hFF, 0,    0, 0,   8,  5'h01, 1, 1, 0);  // missing eop
        add_vec(1, 1, 0, 8'hFF, 0,    0, 1,   8,  5'h09, 1, 2, 0);
        add_vec(1, 0, 0, 8'hFF, 8,    1, 0,   8,  5'h09, 1, 2, 0);
        add_vec(1, 0, 1, 8'hFF, 16,   0, 1,   24, 5'h00, 2, 2, 0);
        add_vec(1, 1, 0, 8'hFF, 0,    0, 0,   24, 5'h00, 2, 2, 0);  // middle be=FE
        add_vec(1, 0, 0, 8'hFE, 8,    1, 0,   24, 5'h00, 2, 2, 0);
        add_vec(1, 0, 1, 8'hFF, 16,   0, 1,   23, 5'h04, 2, 3, 0);
        add_vec(1, 1, 0, 8'hFF, 0,    0, 0,   23, 5'h04, 2, 3, 0);  // eop be=0F
        add_vec(1, 0, 1, 8'h0F, 8,    0, 1,   12, 5'h05, 2, 4, 0);
        add_vec(1, 0, 0, 8'hFF, 0,    0, 0,   12, 5'h05, 2, 4, 1);  // orphans
        add_vec(0, 1, 1, 8'hFF, 0,    0, 0,   12, 5'h05, 2, 4, 1);
        add_vec(1, 0, 1, 8'hFF, 0,    0, 0,   12, 5'h05, 2, 4, 2);
        add_vec(1, 0, 0, 8'hFF, 0,    0, 0,   12, 5'h05, 2, 4, 3);
        add_vec(1, 1, 0, 8'hFF, 0,    0, 0,   12, 5'h05, 2, 4, 3);  // sop+eop while open
        add_vec(1, 1, 1, 8'hFF, 0,    0, 1,   8,  5'h09, 2, 5, 4);
        add_vec(1, 1, 0, 8'hFF, 0,    0, 0,   8,  5'h09, 2, 5, 4);  // 14B: hv with done
        add_vec(1, 0, 1, 8'hFC, 8,    1, 1,   14, 5'h00, 3, 5, 4);

        valid = 0; sop = 0; eop = 0; be = '0; data = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        m_reset();
        compare_all("reset");
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            beat($sformatf("v%0d", i), tbl[i].v, tbl[i].s, tbl[i].e, tbl[i].b, mk(tbl[i].base));
            chk($sformatf("tbl%0d_hv", i), hdr_valid, tbl[i].hv);
            chk($sformatf("tbl%0d_done", i), pkt_done, tbl[i].done);
            chk($sformatf("tbl%0d_len", i), pkt_len, 128'(tbl[i].len));
            chk($sformatf("tbl%0d_flags", i), pkt_err_flags, tbl[i].fl);
            chk($sformatf("tbl%0d_pkt_cnt", i), pkt_cnt, 128'(tbl[i].pkt));
            chk($sformatf("tbl%0d_err_cnt", i), err_cnt, 128'(tbl[i].err));
            chk($sformatf("tbl%0d_drop_cnt", i), drop_cnt, 128'(tbl[i].drop));
            if (i == 1) chk("tbl_hdr_bytes", hdr_data, 112'h000102030405060708090a0b0c0d);
        end

        // 1600-byte packet crosses the maximum length
        beat("big_sop", 1, 1, 0, 8'hFF, mk(0));
        for (int i = 1; i < 199; i++) beat("big_mid", 1, 0, 0, 8'hFF, mk(8 * i));
        beat("big_eop", 1, 0, 1, 8'hFF, mk(1592));
        chk("oversize_done", pkt_done, 1'b1);
        chk("oversize_len", pkt_len, 128'(1600));
        chk("oversize_flags", pkt_err_flags, 5'h02);

        // reset in the middle of a packet
        beat("pre_rst0", 1, 1, 0, 8'hFF, mk(0));
        beat("pre_rst1", 1, 0, 0, 8'hFF, mk(8));
        valid = 0;
        rst_n = 1'b0;
        #2;
        m_reset();
        compare_all("in_rst");
        @(posedge clk);
        #1;
        compare_all("in_rst_hold");
        rst_n = 1'b1;
        beat("post_rst0", 1, 0, 0, 8'hFF, mk(16));
        beat("post_rst1", 1, 0, 1, 8'hFF, mk(24));
        chk("post_rst_drop", drop_cnt, 128'(2));
        chk("post_rst_no_done", pkt_done, 1'b0);

        // random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            bit         v;
            bit         s;
            bit         e;
            logic [7:0] b;
            logic [63:0] d;
            d = {$urandom, $urandom};
            v = ($urandom_range(0, 7) != 0);
            if (!m_open) begin
                s = ($urandom_range(0, 9) != 0);
                e = s ? ($urandom_range(0, 7) == 0) : 1'($urandom_range(0, 1));
            end else begin
                s = ($urandom_range(0, 19) == 0);
                e = ($urandom_range(0, 5) == 0);
            end
            if (e) b = ($urandom_range(0, 9) != 0) ? legal_eop[$urandom_range(0, 7)] : 8'($urandom);
            else   b = ($urandom_range(0, 19) != 0) ? 8'hFF : 8'($urandom);
            beat("rnd", v, s, e, b, d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
